// File: rtl/nonce_scheduler.sv
// ============================================================================
// Module   : nonce_scheduler
// Purpose  : Job-level controller for one SHA-256 core. Walks an inclusive
//            nonce range (wrapping through all-ones), issues one hash per
//            nonce over a start/done handshake, compares each digest against
//            a 256-bit target and reports the first winner or exhaustion.
// Options  : NS_TIMEOUT_EN - enables the WAIT-state watchdog (TIMEOUT_CYCLES)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_scheduler #(
    parameter int NONCE_W        = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [255:0]       target,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [255:0]       core_digest,
    output logic               job_busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic [31:0]        hashes_done,
    output logic               timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NONCE_W-1:0] cur_q, cur_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [255:0]       tgt_q, tgt_d;
    logic [255:0]       dig_q, dig_d;
    logic               found_q, found_d;
    logic               exh_q, exh_d;
    logic [31:0]        hashes_q, hashes_d;

    logic w_accept;
    logic w_hit;
    logic w_last;
    logic w_tmo_fire;

    // A job is only accepted from IDLE, and abort always takes priority.
    assign w_accept = (state_q == S_IDLE) && job_start && !abort;
    assign w_hit    = (dig_q < tgt_q);
    assign w_last   = (cur_q == end_q);

`ifdef NS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q;
    logic          tmo_q;

    // Watchdog counter: held at zero outside WAIT so every WAIT entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tcnt_q <= '0;
        else if (state_q != S_WAIT) tcnt_q <= '0;
        else                        tcnt_q <= tcnt_q + TW'(1);
    end

    // Fires on the last permitted WAIT cycle; a core_done in that cycle still wins.
    assign w_tmo_fire = (state_q == S_WAIT) && !core_done && !abort &&
                        (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Sticky timeout flag, cleared only by an accepted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          tmo_q <= 1'b0;
        else if (w_accept)   tmo_q <= 1'b0;
        else if (w_tmo_fire) tmo_q <= 1'b1;
    end

    assign timeout_err = tmo_q;
`else
    assign w_tmo_fire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (job_start) state_d = S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (core_done)       state_d = S_CHECK;
                    else if (w_tmo_fire) state_d = S_IDLE;
                end
                S_CHECK: state_d = (w_hit || w_last) ? S_IDLE : S_ISSUE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: start pulse is suppressed by a same-cycle abort.
    always_comb begin
        core_start = (state_q == S_ISSUE) && !abort;
        job_busy   = (state_q != S_IDLE);
    end

    // Datapath next values: job latch, digest capture, compare result, nonce step.
    always_comb begin
        cur_d         = cur_q;
        end_d         = end_q;
        tgt_d         = tgt_q;
        dig_d         = dig_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        exh_d         = exh_q;
        hashes_d      = hashes_q;
        if (abort) begin
            found_d = 1'b0;
            exh_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (job_start) begin
                        cur_d    = nonce_start;
                        end_d    = nonce_end;
                        tgt_d    = target;
                        found_d  = 1'b0;
                        exh_d    = 1'b0;
                        hashes_d = '0;
                    end
                end
                S_WAIT: begin
                    if (core_done) dig_d = core_digest;
                end
                S_CHECK: begin
                    if (hashes_q != 32'hFFFF_FFFF) hashes_d = hashes_q + 32'd1;
                    if (w_hit) begin
                        found_d       = 1'b1;
                        found_nonce_d = cur_q;
                    end else if (w_last) begin
                        exh_d = 1'b1;
                    end else begin
                        cur_d = cur_q + NONCE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q         <= '0;
            end_q         <= '0;
            tgt_q         <= '0;
            dig_q         <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exh_q         <= 1'b0;
            hashes_q      <= '0;
        end else begin
            cur_q         <= cur_d;
            end_q         <= end_d;
            tgt_q         <= tgt_d;
            dig_q         <= dig_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            exh_q         <= exh_d;
            hashes_q      <= hashes_d;
        end
    end

    assign core_nonce  = cur_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign exhausted   = exh_q;
    assign hashes_done = hashes_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
// ============================================================================
// Module   : tb_nonce_scheduler
// Purpose  : Scoreboard bench for nonce_scheduler with a behavioural hash-core
//            responder and a range-walking reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic         core_done = 1'b0;
    logic [255:0] core_digest = '0;
    logic         core_start;
    logic [31:0]  core_nonce;
    logic         job_busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic         exhausted;
    logic [31:0]  hashes_done;
    logic         timeout_err;

    always #5 clk = ~clk;

    nonce_scheduler #(.NONCE_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .abort(abort),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_digest(core_digest),
        .job_busy(job_busy), .found(found), .found_nonce(found_nonce),
        .exhausted(exhausted), .hashes_done(hashes_done),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic        found;
        logic        exh;
        logic        tmo;
        logic [31:0] fn;
        logic [31:0] hashes;
    } res_t;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_nonce_q[$];
    res_t        exp_res_q[$];

    // Environment knobs for the behavioural hash core.
    int          dmode = 0;
    logic [31:0] dseed = 32'h1234_5678;
    logic [31:0] dhit  = '0;
    int          lat   = 2;
    bit          core_mute = 1'b0;
    logic [31:0] model_fn = '0;

    function automatic logic [255:0] dig_of(input logic [31:0] n);
        logic [31:0] h;
        h = (n ^ dseed) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        if (dmode == 1) return (n == dhit) ? 256'd0 : {256{1'b1}};
        return {h, ~h, {6{h ^ 32'h5A5A_5A5A}}};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hash core: answers lat+1 cycles after seeing core_start, unless muted.
    initial begin : core_model
        logic [31:0] n;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && !core_mute) begin
                n = core_nonce;
                repeat (lat + 1) @(negedge clk);
                core_digest = dig_of(n);
                core_done   = 1'b1;
                check("core_nonce_stable", core_nonce, n);
                @(negedge clk);
                core_done   = 1'b0;
                core_digest = {8{$urandom}};
            end
        end
    end

    // Monitor: every core_start must match the next expected nonce.
    initial begin : start_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                if (exp_nonce_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_core_start: got nonce %0h expected none", core_nonce);
                end else begin
                    e = exp_nonce_q.pop_front();
                    check("core_nonce", core_nonce, e);
                end
            end
        end
    end

    // Monitor: at the end of every job compare the result flags.
    initial begin : end_mon
        bit   prev;
        res_t r;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev && !job_busy) begin
                if (exp_res_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_job_end: got busy fall expected none");
                end else begin
                    r = exp_res_q.pop_front();
                    check("found",       found,       r.found);
                    check("exhausted",   exhausted,   r.exh);
                    check("timeout_err", timeout_err, r.tmo);
                    check("found_nonce", found_nonce, r.fn);
                    check("hashes_done", hashes_done, r.hashes);
                    check("found_exh_mutex", found & exhausted, 1'b0);
                end
            end
            prev = job_busy;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_res_q.size() != 0) && (k < 5000)) begin
            @(negedge clk);
            k++;
        end
        if (exp_res_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL job_timeout: got %0d pending results expected 0", exp_res_q.size());
            exp_res_q.delete();
            exp_nonce_q.delete();
        end
        check("nonces_pending", exp_nonce_q.size(), 0);
    endtask

    // Reference model: walk the range, first digest below target wins.
    task automatic job(input logic [31:0] s, input logic [31:0] e,
                       input logic [255:0] t, input bit poke);
        res_t        r;
        logic [31:0] n;
        int          cnt;
        r.found = 1'b0;
        r.exh   = 1'b0;
        r.tmo   = 1'b0;
        cnt     = 0;
        n       = s;
        forever begin
            exp_nonce_q.push_back(n);
            cnt++;
            if (dig_of(n) < t) begin
                r.found  = 1'b1;
                model_fn = n;
                break;
            end
            if (n == e) begin
                r.exh = 1'b1;
                break;
            end
            n = n + 32'd1;
        end
        r.fn     = model_fn;
        r.hashes = cnt;
        exp_res_q.push_back(r);
        @(negedge clk);
        nonce_start = s;
        nonce_end   = e;
        target      = t;
        job_start   = 1'b1;
        @(negedge clk);
        job_start   = 1'b0;
        nonce_start = $urandom;
        nonce_end   = $urandom;
        target      = {8{$urandom}};
        if (poke) begin
            job_start = 1'b1;
            @(negedge clk);
            job_start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin : stim
        res_t r;
        int   seen;
        int   k;
        logic [31:0] s;
        logic [255:0] t;

        repeat (3) @(negedge clk);
        check("rst_core_start",  core_start,  1'b0);
        check("rst_core_nonce",  core_nonce,  32'd0);
        check("rst_job_busy",    job_busy,    1'b0);
        check("rst_found",       found,       1'b0);
        check("rst_found_nonce", found_nonce, 32'd0);
        check("rst_exhausted",   exhausted,   1'b0);
        check("rst_hashes",      hashes_done, 32'd0);
        check("rst_timeout",     timeout_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single nonce, always-winning target.
        lat = 4;
        job(32'h5, 32'h5, {256{1'b1}}, 1'b0);
        // Range miss.
        lat = 1;
        job(32'h10, 32'h13, 256'd0, 1'b0);
        // Hit in the middle of a range.
        dmode = 1; dhit = 32'h142; lat = 0;
        job(32'h100, 32'h1FF, 256'd1, 1'b0);
        dmode = 0;
        // Wrap-around through all-ones.
        job(32'hFFFF_FFFE, 32'h1, 256'd0, 1'b0);

        // Abort during WAIT of the third nonce; the late answer must be ignored.
        lat = 6;
        exp_nonce_q.push_back(32'h20);
        exp_nonce_q.push_back(32'h21);
        exp_nonce_q.push_back(32'h22);
        r.found = 1'b0; r.exh = 1'b0; r.tmo = 1'b0; r.fn = model_fn; r.hashes = 32'd2;
        exp_res_q.push_back(r);
        @(negedge clk);
        nonce_start = 32'h20; nonce_end = 32'h27; target = 256'd0; job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        seen = (core_start === 1'b1) ? 1 : 0;
        k = 0;
        while (seen < 3 && k < 200) begin
            @(negedge clk);
            if (core_start === 1'b1) seen++;
            k++;
        end
        check("abort_reached_third", seen, 3);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", job_busy, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_busy_late",  job_busy,    1'b0);
        check("abort_hashes",     hashes_done, 32'd2);
        check("abort_found",      found,       1'b0);
        check("abort_exhausted",  exhausted,   1'b0);
        check("abort_result_seen", exp_res_q.size(), 0);

        // Abort and job_start together: job must not be accepted.
        job_start = 1'b1; abort = 1'b1;
        nonce_start = 32'h40; nonce_end = 32'h41; target = {256{1'b1}};
        @(negedge clk);
        job_start = 1'b0; abort = 1'b0;
        check("abort_start_busy", job_busy, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_start_busy2",  job_busy,    1'b0);
        check("abort_start_hashes", hashes_done, 32'd2);

        // Randomised jobs, some with a job_start pulse while busy.
        for (int i = 0; i < 30; i++) begin
            s = $urandom;
            if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0:       t = 256'd0;
                1:       t = {256{1'b1}};
                default: t = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
            endcase
            dseed = $urandom;
            lat   = $urandom_range(0, 5);
            job(s, s + $urandom_range(0, 12), t, bit'($urandom_range(0, 1)));
        end

`ifdef NS_TIMEOUT_EN
        // Silent core: watchdog must fire exactly 8 cycles after WAIT entry.
        core_mute = 1'b1;
        exp_nonce_q.push_back(32'h7);
        r.found = 1'b0; r.exh = 1'b0; r.tmo = 1'b1; r.fn = model_fn; r.hashes = 32'd0;
        exp_res_q.push_back(r);
        @(negedge clk);
        nonce_start = 32'h7; nonce_end = 32'h7; target = {256{1'b1}}; job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        repeat (8) @(negedge clk);
        check("tmo_not_yet", timeout_err, 1'b0);
        check("tmo_busy",    job_busy,    1'b1);
        @(negedge clk);
        check("tmo_fired",   timeout_err, 1'b1);
        check("tmo_idle",    job_busy,    1'b0);
        wait_idle();
        core_mute = 1'b0;
        lat = 1;
        job(32'h3, 32'h3, {256{1'b1}}, 1'b0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
